mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single unified 16-bit instruction/data memory between two requesters: instruction fetch and data load/store of the multicycle CPU.
- Sits between the controller/datapath and the memory.
- Drives one address bus and generates clean, edge-qualified memRead/memWrite strobes. The memory acts on strobe rising edges, so each strobe is low for at least one cycle between accesses.
- Returns registered read data to each requester with a one-cycle ready pulse.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 16, memory word width.
- FAIR, 1. 1 = round-robin on simultaneous requests; 0 = data port always wins.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- instReq  in  1  fetch request; level, held until instReady.
- instAdd  in  ADDR_W  fetch address; stable while instReq=1.
- instReady  out  1  one-cycle pulse: fetch complete, instOut valid.
- instOut  out  DATA_W  last fetched word; registered, held.
- dataReq  in  1  data request; level, held until dataReady.
- dataWe  in  1  1 = store, 0 = load; stable while dataReq=1.
- dataAdd  in  ADDR_W  data address; stable while dataReq=1.
- dataWrite  in  DATA_W  store data; stable while dataReq=1.
- dataReady  out  1  one-cycle pulse: data access complete.
- dataOut  out  DATA_W  last loaded word; registered, held.
- memAdd  out  ADDR_W  address to memory (both its instruction and data address inputs).
- memWriteData  out  DATA_W  write data to memory.
- memRead  out  1  read strobe.
- memWrite  out  1  write strobe.
- memData  in  DATA_W  read data from memory.
- busy  out  1  1 whenever state != IDLE.
- grantData  out  1  current/last owner: 1 = data, 0 = inst.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - memRead=memWrite=0, instReady=dataReady=0.
  - instOut=dataOut=0, memAdd=0, memWriteData=0, busy=0.
  - lastGrant=inst, so the first conflict goes to data.
- FSM states: IDLE, SETUP, STROBE, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise arbitrate:
    - Only one requester: grant it.
    - Both requesting, FAIR=1: grant the one not equal to lastGrant.
    - Both requesting, FAIR=0: grant data.
  - On grant, latch memAdd, memWriteData and the write flag (inst is always a read; data uses dataWe), set grantData, then go to SETUP.
- SETUP: strobes held 0 and address stable; go to STROBE.
- STROBE:
  - Assert exactly one strobe for this cycle: memWrite if the latched write flag is set, else memRead.
  - Go to DONE.
- DONE:
  - Strobes 0.
  - Read: capture memData into instOut or dataOut (per owner) at the entering edge.
  - Pulse the owner's ready for exactly this cycle.
  - Update lastGrant; go to IDLE.
- Latency: request sampled at edge 0, then strobe high after edge 1, then ready high after edge 2, then IDLE after edge 3.
  - 4 cycles per access, including the mandatory IDLE gap.
  - Between back-to-back strobes there are at least 2 low cycles.
- Stores leave dataOut unchanged. Loads leave instOut unchanged, and vice versa.
- Request dropped mid-transaction: the access still completes and the ready still pulses; the requester must ignore it. No abort.
- Request inputs are sampled only in IDLE. Address or data changes after the grant are ignored.
- A requester holding its req through the ready cycle is re-sampled in IDLE and gets a new access. Requesters must drop req on the cycle after ready.
- Reset mid-operation: strobes drop immediately, no ready is issued, and the partial access is discarded. A memory write already strobed is not undone.
- Never assert memRead and memWrite together. Never assert both readys together.
- Widths are passed through unchanged; no arithmetic.

Test Plan:
- Reset: hold rst=0 with requests active, release -> all outputs 0, first access starts only at the first edge after release, and memRead=memWrite=0 throughout reset.
- Single fetch:
  - Stimulus: instReq=1, instAdd=0x002, memory word 0xC40A.
  - Required response: memAdd=0x002 after edge 1, memRead=1 exactly one cycle after edge 2.
  - Then instReady=1 for one cycle after edge 3 with instOut=0xC40A; busy is 1 during those 3 cycles.
- Store then load:
  - Stimulus: dataReq/dataWe=1, dataAdd=0x1FE, dataWrite=0xABCD; then a load from 0x1FE.
  - Required response: a single memWrite pulse with memWriteData=0xABCD, dataOut unchanged after the store, then dataOut=0xABCD after the load.
- Conflict with FAIR=1:
  - Stimulus: instReq and dataReq both held high continuously.
  - Required response: grants alternate data, inst, data, inst.
  - Each access takes 4 cycles, and the strobes are never simultaneous.
- Conflict with FAIR=0: same stimulus -> data granted every time and inst starved until dataReq drops, then inst is served in the next IDLE.
- Reset during STROBE: assert rst=0 while memRead=1 -> memRead falls immediately, no ready pulse, and state is IDLE after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified instruction/data memory between the fetch
// and load/store requesters of the multicycle CPU. Each access walks
// IDLE -> SETUP -> STROBE -> DONE so the memory always sees a clean,
// single-cycle read or write strobe with a stable address around it.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int FAIR   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instReq,
    input  logic [ADDR_W-1:0] instAdd,
    output logic              instReady,
    output logic [DATA_W-1:0] instOut,
    input  logic              dataReq,
    input  logic              dataWe,
    input  logic [ADDR_W-1:0] dataAdd,
    input  logic [DATA_W-1:0] dataWrite,
    output logic              dataReady,
    output logic [DATA_W-1:0] dataOut,
    output logic [ADDR_W-1:0] memAdd,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] memData,
    output logic              busy,
    output logic              grantData
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_grant;
    logic              w_sel_data;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_inst_ready;
    logic              w_data_ready;
    logic              w_cap_inst;
    logic              w_cap_data;

    logic [ADDR_W-1:0] r_mem_add;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_grant_data;
    logic              r_last_grant;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_inst_ready;
    logic              r_data_ready;
    logic [DATA_W-1:0] r_inst_out;
    logic [DATA_W-1:0] r_data_out;
    logic              r_busy;

    // Next state, arbitration, and next values of the registered outputs
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_sel_data   = 1'b0;
        case (r_state)
            IDLE: begin
                if (instReq || dataReq) begin
                    w_grant      = 1'b1;
                    // lastGrant: 1 = data, 0 = inst
                    w_sel_data   = dataReq && (!instReq || (FAIR == 0) || !r_last_grant);
                    w_next_state = SETUP;
                end
            end
            SETUP:   w_next_state = STROBE;
            STROBE:  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        w_mem_read   = (w_next_state == STROBE) && !r_we;
        w_mem_write  = (w_next_state == STROBE) && r_we;
        w_inst_ready = (w_next_state == DONE) && !r_grant_data;
        w_data_ready = (w_next_state == DONE) && r_grant_data;
        w_cap_inst   = (r_state == STROBE) && !r_we && !r_grant_data;
        w_cap_data   = (r_state == STROBE) && !r_we && r_grant_data;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered outputs, latched request fields and captured read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_add    <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_grant_data <= 1'b0;
            r_last_grant <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            r_inst_out   <= '0;
            r_data_out   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_inst_ready <= w_inst_ready;
            r_data_ready <= w_data_ready;
            r_busy       <= (w_next_state != IDLE);
            if (w_grant) begin
                r_mem_add    <= w_sel_data ? dataAdd : instAdd;
                r_we         <= w_sel_data && dataWe;
                r_grant_data <= w_sel_data;
                if (w_sel_data) begin
                    r_wdata <= dataWrite;
                end
            end
            if (w_cap_inst) begin
                r_inst_out <= memData;
            end
            if (w_cap_data) begin
                r_data_out <= memData;
            end
            if (r_state == DONE) begin
                r_last_grant <= r_grant_data;
            end
        end
    end

    assign memAdd       = r_mem_add;
    assign memWriteData = r_wdata;
    assign memRead      = r_mem_read;
    assign memWrite     = r_mem_write;
    assign instReady    = r_inst_ready;
    assign dataReady    = r_data_ready;
    assign instOut      = r_inst_out;
    assign dataOut      = r_data_out;
    assign busy         = r_busy;
    assign grantData    = r_grant_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench. DUT "a" is round-robin (FAIR=1),
// DUT "b" is data-priority (FAIR=0); both read one shared memory model.
module tb_mem_arbiter;

    typedef struct packed {
        logic        is_data;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  instAdd, dataAdd;
    logic        dataWe;
    logic [15:0] dataWrite;
    logic        a_ireq, a_dreq, b_ireq, b_dreq;

    logic        a_instReady, a_dataReady, a_memRead, a_memWrite, a_busy, a_grantData;
    logic [15:0] a_instOut, a_dataOut, a_memWriteData, a_memData;
    logic [9:0]  a_memAdd;
    logic        b_instReady, b_dataReady, b_memRead, b_memWrite, b_busy, b_grantData;
    logic [15:0] b_instOut, b_dataOut, b_memWriteData, b_memData;
    logic [9:0]  b_memAdd;

    logic [15:0] mem [0:1023];
    logic [9:0]  pre_a;
    logic [15:0] pre_d;
    logic        pre_we = 1'b0;
    int          wr_cnt = 0;

    exp_t        qa[$];
    exp_t        qb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          a_gap = 0;
    bit          a_seen = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(10), .DATA_W(16), .FAIR(1)) u_a (
        .clk(clk), .rst(rst),
        .instReq(a_ireq), .instAdd(instAdd), .instReady(a_instReady), .instOut(a_instOut),
        .dataReq(a_dreq), .dataWe(dataWe), .dataAdd(dataAdd), .dataWrite(dataWrite),
        .dataReady(a_dataReady), .dataOut(a_dataOut),
        .memAdd(a_memAdd), .memWriteData(a_memWriteData), .memRead(a_memRead),
        .memWrite(a_memWrite), .memData(a_memData), .busy(a_busy), .grantData(a_grantData)
    );

    mem_arbiter #(.ADDR_W(10), .DATA_W(16), .FAIR(0)) u_b (
        .clk(clk), .rst(rst),
        .instReq(b_ireq), .instAdd(instAdd), .instReady(b_instReady), .instOut(b_instOut),
        .dataReq(b_dreq), .dataWe(dataWe), .dataAdd(dataAdd), .dataWrite(dataWrite),
        .dataReady(b_dataReady), .dataOut(b_dataOut),
        .memAdd(b_memAdd), .memWriteData(b_memWriteData), .memRead(b_memRead),
        .memWrite(b_memWrite), .memData(b_memData), .busy(b_busy), .grantData(b_grantData)
    );

    assign a_memData = mem[a_memAdd];
    assign b_memData = mem[b_memAdd];

    // Memory model: writes on the rising edge of the write strobe, plus preload
    always @(posedge a_memWrite or posedge pre_we) begin
        if (pre_we) begin
            mem[pre_a] = pre_d;
        end else begin
            mem[a_memAdd] = a_memWriteData;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] ad, input logic [15:0] d);
        pre_a  = ad;
        pre_d  = d;
        pre_we = 1'b1;
        #1;
        pre_we = 1'b0;
        #1;
    endtask

    // One access on DUT a; the expected result goes to the scoreboard first
    task automatic a_access(input bit d, input bit we, input logic [9:0] ad,
                            input logic [15:0] wd, input logic [15:0] expv, output bit ok);
        ok = 1'b0;
        if (d) begin
            dataAdd = ad; dataWe = we; dataWrite = wd;
        end else begin
            instAdd = ad;
        end
        qa.push_back('{d, expv});
        if (d) a_dreq = 1'b1; else a_ireq = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d ? a_dataReady : a_instReady) begin
                ok = 1'b1;
                break;
            end
        end
        a_dreq = 1'b0;
        a_ireq = 1'b0;
        @(negedge clk);
    endtask

    // Monitor a: strobe/ready exclusivity, strobe spacing, scoreboard pop
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("a_strobe_excl", 32'(a_memRead & a_memWrite), 32'd0);
            check("a_ready_excl", 32'(a_instReady & a_dataReady), 32'd0);
            if (a_memRead || a_memWrite) begin
                if (a_seen) check("a_strobe_gap", 32'(a_gap >= 2), 32'd1);
                a_seen = 1'b1;
                a_gap  = 0;
            end else begin
                a_gap++;
            end
            if (a_instReady || a_dataReady) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    check("a_owner", 32'(a_dataReady), 32'(e.is_data));
                    check("a_rdata", 32'(e.is_data ? a_dataOut : a_instOut), 32'(e.val));
                end
            end
        end
    end

    // Monitor b: exclusivity and scoreboard pop
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("b_strobe_excl", 32'(b_memRead & b_memWrite), 32'd0);
            if (b_instReady || b_dataReady) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    check("b_owner", 32'(b_dataReady), 32'(e.is_data));
                    check("b_rdata", 32'(e.is_data ? b_dataOut : b_instOut), 32'(e.val));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n, nd, ni, last;
        rst = 1'b0;
        a_ireq = 1'b1; a_dreq = 1'b0; b_ireq = 1'b0; b_dreq = 1'b0;
        instAdd = 10'h002; dataAdd = '0; dataWe = 1'b0; dataWrite = '0;
        preload(10'h002, 16'hC40A);
        preload(10'h010, 16'h1111);
        preload(10'h020, 16'h2222);

        // Reset held with a request active
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_strobes", {28'd0, a_memRead, a_memWrite, b_memRead, b_memWrite}, 32'd0);
            check("rst_busy", 32'(a_busy), 32'd0);
        end
        check("rst_outs", {a_instOut, a_dataOut}, 32'd0);
        check("rst_bus", {a_memAdd, a_memWriteData}, 32'd0);
        check("rst_flags", {29'd0, a_instReady, a_dataReady, a_grantData}, 32'd0);

        // Release: fetch from 0x002 starts at the first edge
        qa.push_back('{1'b0, 16'hC40A});
        rst = 1'b1;
        @(negedge clk);
        check("f_e0_add", 32'(a_memAdd), 32'h002);
        check("f_e0_busy", 32'(a_busy), 32'd1);
        check("f_e0_rd", 32'(a_memRead), 32'd0);
        @(negedge clk);
        check("f_e1_rd", 32'(a_memRead), 32'd1);
        check("f_e1_busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        check("f_e2_rd", 32'(a_memRead), 32'd0);
        check("f_e2_rdy", 32'(a_instReady), 32'd1);
        check("f_e2_iout", 32'(a_instOut), 32'hC40A);
        check("f_e2_busy", 32'(a_busy), 32'd1);
        a_ireq = 1'b0;
        @(negedge clk);
        check("f_e3_rdy", 32'(a_instReady), 32'd0);
        check("f_e3_busy", 32'(a_busy), 32'd0);
        @(negedge clk);

        // Round-robin conflict: data, inst, data, inst every 4 cycles
        instAdd = 10'h010; dataAdd = 10'h020; dataWe = 1'b0;
        qa.push_back('{1'b1, 16'h2222});
        qa.push_back('{1'b0, 16'h1111});
        qa.push_back('{1'b1, 16'h2222});
        qa.push_back('{1'b0, 16'h1111});
        a_ireq = 1'b1; a_dreq = 1'b1;
        n = 0; last = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (a_instReady || a_dataReady) begin
                if (n > 0) check("fair_period", 32'(c - last), 32'd4);
                last = c;
                n++;
            end
        end
        a_ireq = 1'b0; a_dreq = 1'b0;
        check("fair_count", 32'(n), 32'd4);
        repeat (2) @(negedge clk);
        check("fair_idle", 32'(a_busy), 32'd0);

        // Store 0xABCD to 0x1FE: dataOut keeps the last load (0x2222)
        n = wr_cnt;
        a_access(1'b1, 1'b1, 10'h1FE, 16'hABCD, 16'h2222, ok);
        check("st_done", 32'(ok), 32'd1);
        check("st_writes", 32'(wr_cnt - n), 32'd1);
        check("st_mem", 32'(mem[10'h1FE]), 32'hABCD);
        check("st_wdata", 32'(a_memWriteData), 32'hABCD);

        // Load back from 0x1FE; instOut untouched
        a_access(1'b1, 1'b0, 10'h1FE, 16'h0000, 16'hABCD, ok);
        check("ld_done", 32'(ok), 32'd1);
        check("ld_iout", 32'(a_instOut), 32'h1111);
        check("ld_writes", 32'(wr_cnt - n), 32'd1);

        // Data-priority DUT: inst starved until dataReq drops
        instAdd = 10'h010; dataAdd = 10'h020; dataWe = 1'b0;
        for (int k = 0; k < 3; k++) qb.push_back('{1'b1, 16'h2222});
        qb.push_back('{1'b0, 16'h1111});
        b_ireq = 1'b1; b_dreq = 1'b1;
        nd = 0; ni = 0; last = 0;
        for (int c = 0; c < 60 && ni == 0; c++) begin
            @(negedge clk);
            if (b_dataReady) begin
                nd++;
                last = c;
                if (nd == 3) b_dreq = 1'b0;
            end
            if (b_instReady) begin
                ni++;
                b_ireq = 1'b0;
                check("prio_inst_delay", 32'(c - last), 32'd4);
            end
        end
        b_ireq = 1'b0; b_dreq = 1'b0;
        check("prio_data_cnt", 32'(nd), 32'd3);
        check("prio_inst_cnt", 32'(ni), 32'd1);
        repeat (2) @(negedge clk);

        // Reset while memRead is high: strobe drops, no ready, back to IDLE
        dataAdd = 10'h020; dataWe = 1'b0;
        a_dreq = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_memRead) begin
                ok = 1'b1;
                break;
            end
        end
        check("rs_saw_strobe", 32'(ok), 32'd1);
        rst = 1'b0;
        #1;
        check("rs_rd_drop", 32'(a_memRead), 32'd0);
        check("rs_busy", 32'(a_busy), 32'd0);
        check("rs_dout", 32'(a_dataOut), 32'd0);
        a_dreq = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rs_no_ready", {30'd0, a_instReady, a_dataReady}, 32'd0);
            check("rs_idle", 32'(a_busy), 32'd0);
        end

        check("sb_a_empty", 32'(qa.size()), 32'd0);
        check("sb_b_empty", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
